// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if
// Groups the CSR controls, trigger, DPRAM write-controller handshake and
// status outputs of the capture sequencer. The master side is the
// CSR/trigger/DPRAM environment; the slave side is the sequencer itself.
`timescale 1ns/1ps

interface adc_capture_sequencer_if;
  logic        csr_arm_i;
  logic        csr_abort_i;
  logic [7:0]  csr_num_caps_i;
  logic [15:0] csr_holdoff_i;
  logic        trig_i;
  logic        cap_done_i;
  logic        cap_start_o;
  logic        busy_o;
  logic [7:0]  cap_count_o;
  logic        irq_o;
  logic        timeout_o;
  logic [2:0]  state_o;

  modport master (
    output csr_arm_i, csr_abort_i, csr_num_caps_i, csr_holdoff_i,
           trig_i, cap_done_i,
    input  cap_start_o, busy_o, cap_count_o, irq_o, timeout_o, state_o
  );

  modport slave (
    input  csr_arm_i, csr_abort_i, csr_num_caps_i, csr_holdoff_i,
           trig_i, cap_done_i,
    output cap_start_o, busy_o, cap_count_o, irq_o, timeout_o, state_o
  );
endinterface

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
// Sequences a number of ADC buffer captures through a DPRAM write
// controller: start level while capturing, masked/acknowledged done,
// programmable gap between captures, capture watchdog and abort.
// Optional feature macro: ADC_SEQ_EXT_TRIG_EN -- when defined each capture
// waits for a synchronised rising edge of trig_i; otherwise captures start
// back to back and trig_i is unused.
`timescale 1ns/1ps

module adc_capture_sequencer #(
  parameter int HOLDOFF_MIN = 2,
  parameter int TIMEOUT_CYC = 8192,
  parameter int DONE_MASK   = 2
) (
  input logic                     sys_clk,
  input logic                     sys_rst_n,
  adc_capture_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    CAPTURE   = 3'd2,
    HOLDOFF   = 3'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        cap_start;
  logic        busy;
  logic [7:0]  cap_count;
  logic        irq;
  logic        timeout;
  logic [7:0]  num_caps_q;
  logic [15:0] holdoff_q;
  logic [15:0] cap_cyc;
  logic [15:0] hold_cnt;
  logic [15:0] hold_load;
  logic [7:0]  count_inc;
  logic        done_accept;
  logic        last_cap;
  logic        wd_expire;
  logic        trig_rise;

`ifdef ADC_SEQ_EXT_TRIG_EN
  localparam state_t START_STATE = WAIT_TRIG;

  logic trig_meta;
  logic trig_sync;
  logic trig_prev;

  // Two-flop synchroniser for the asynchronous trigger plus a delay flop for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_meta <= bus.trig_i;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
    end
  end

  assign trig_rise = trig_sync & ~trig_prev;
`else
  localparam state_t START_STATE = CAPTURE;

  logic unused_trig;
  assign unused_trig = bus.trig_i;
  assign trig_rise   = 1'b0;
`endif

  assign count_inc   = cap_count + 8'd1;
  assign hold_load   = (holdoff_q < 16'(HOLDOFF_MIN)) ? 16'(HOLDOFF_MIN) : holdoff_q;
  assign done_accept = (state == CAPTURE) && (cap_cyc >= 16'(DONE_MASK)) && bus.cap_done_i;
  assign last_cap    = (num_caps_q != 8'd0) && (count_inc == num_caps_q);
  assign wd_expire   = (state == CAPTURE) && !done_accept && (cap_cyc == 16'(TIMEOUT_CYC - 1));

  // Next-state selection; abort overrides every other request
  always_comb begin
    state_nxt = state;
    if (bus.csr_abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (bus.csr_arm_i) state_nxt = START_STATE;
        WAIT_TRIG: if (trig_rise) state_nxt = CAPTURE;
        CAPTURE: begin
          if (done_accept)    state_nxt = last_cap ? IDLE : HOLDOFF;
          else if (wd_expire) state_nxt = IDLE;
        end
        HOLDOFF:   if (hold_cnt <= 16'd1) state_nxt = START_STATE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // State register, registered outputs, counters and sampled configuration
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cap_start  <= 1'b0;
      busy       <= 1'b0;
      cap_count  <= 8'd0;
      irq        <= 1'b0;
      timeout    <= 1'b0;
      num_caps_q <= 8'd0;
      holdoff_q  <= 16'd0;
      cap_cyc    <= 16'd0;
      hold_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      cap_start <= (state_nxt == CAPTURE);
      busy      <= (state_nxt != IDLE);
      irq       <= done_accept && last_cap && !bus.csr_abort_i;
      cap_cyc   <= ((state == CAPTURE) && (state_nxt == CAPTURE)) ? cap_cyc + 16'd1 : 16'd0;

      if ((state == CAPTURE) && (state_nxt == HOLDOFF))
        hold_cnt <= hold_load;
      else if ((state == HOLDOFF) && (state_nxt == HOLDOFF))
        hold_cnt <= hold_cnt - 16'd1;
      else
        hold_cnt <= 16'd0;

      if ((state == IDLE) && bus.csr_arm_i && !bus.csr_abort_i) begin
        cap_count  <= 8'd0;
        timeout    <= 1'b0;
        num_caps_q <= bus.csr_num_caps_i;
        holdoff_q  <= bus.csr_holdoff_i;
      end else begin
        if (done_accept && !bus.csr_abort_i) cap_count <= count_inc;
        if (wd_expire && !bus.csr_abort_i)   timeout   <= 1'b1;
      end
    end
  end

  assign bus.cap_start_o = cap_start;
  assign bus.busy_o      = busy;
  assign bus.cap_count_o = cap_count;
  assign bus.irq_o       = irq;
  assign bus.timeout_o   = timeout;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer
// Directed bench for adc_capture_sequencer with hand-computed expectations.
// Builds with or without ADC_SEQ_EXT_TRIG_EN; each build runs the sequence
// matching its configuration. Inputs are driven and outputs sampled 1 ns
// after the rising clock edge.
`timescale 1ns/1ps

module tb_adc_capture_sequencer;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   errors;
  int   gap;

  adc_capture_sequencer_if bus ();

  adc_capture_sequencer #(
    .HOLDOFF_MIN (2),
    .TIMEOUT_CYC (8192),
    .DONE_MASK   (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // 100 MHz clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Global time limit so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] time limit exceeded");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic arm, input logic abort);
    bus.csr_arm_i   = arm;
    bus.csr_abort_i = abort;
    step(1);
    bus.csr_arm_i   = 1'b0;
    bus.csr_abort_i = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_state"},  16'(bus.state_o),     16'd0);
    check_output({tag, "_busy"},   16'(bus.busy_o),      16'd0);
    check_output({tag, "_start"},  16'(bus.cap_start_o), 16'd0);
    check_output({tag, "_count"},  16'(bus.cap_count_o), 16'd0);
    check_output({tag, "_irq"},    16'(bus.irq_o),       16'd0);
    check_output({tag, "_tmo"},    16'(bus.timeout_o),   16'd0);
  endtask

  // Counts low cycles of cap_start_o starting at the current (already low) cycle
  task automatic measure_gap(output int len);
    len = 1;
    for (int k = 0; k < 60; k++) begin
      step(1);
      if (bus.cap_start_o === 1'b1) break;
      len++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sys_rst_n          = 1'b0;
    bus.csr_arm_i      = 1'b0;
    bus.csr_abort_i    = 1'b0;
    bus.csr_num_caps_i = 8'd0;
    bus.csr_holdoff_i  = 16'd0;
    bus.trig_i         = 1'b0;
    bus.cap_done_i     = 1'b0;

    step(3);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    step(2);

`ifdef ADC_SEQ_EXT_TRIG_EN
    $display("[TB] external trigger build");
    bus.csr_num_caps_i = 8'd1;
    bus.csr_holdoff_i  = 16'd10;
    apply_stimulus(1'b1, 1'b0);
    check_output("arm_wait_state", 16'(bus.state_o), 16'd1);
    check_output("arm_wait_busy", 16'(bus.busy_o), 16'd1);
    check_output("arm_wait_start", 16'(bus.cap_start_o), 16'd0);
    step(4);
    bus.trig_i = 1'b1;
    step(1);
    check_output("trig_sync1", 16'(bus.state_o), 16'd1);
    step(1);
    check_output("trig_sync2", 16'(bus.state_o), 16'd1);
    bus.trig_i = 1'b0;
    step(1);
    check_output("trig_capture", 16'(bus.state_o), 16'd2);
    check_output("trig_start", 16'(bus.cap_start_o), 16'd1);
    step(1);
    bus.cap_done_i = 1'b1;
    step(1);
    check_output("trig_done_masked", 16'(bus.cap_start_o), 16'd1);
    step(1);
    bus.cap_done_i = 1'b0;
    check_output("trig_done_start", 16'(bus.cap_start_o), 16'd0);
    check_output("trig_done_irq", 16'(bus.irq_o), 16'd1);
    check_output("trig_done_count", 16'(bus.cap_count_o), 16'd1);
    check_output("trig_done_state", 16'(bus.state_o), 16'd0);
    step(1);
    check_output("trig_irq_pulse", 16'(bus.irq_o), 16'd0);

    apply_stimulus(1'b1, 1'b1);
    check_output("armabort_state", 16'(bus.state_o), 16'd0);
    check_output("armabort_busy", 16'(bus.busy_o), 16'd0);
    check_output("armabort_count", 16'(bus.cap_count_o), 16'd1);

    apply_stimulus(1'b1, 1'b0);
    check_output("rearm_count", 16'(bus.cap_count_o), 16'd0);
    check_output("rearm_state", 16'(bus.state_o), 16'd1);
    apply_stimulus(1'b0, 1'b1);
    check_output("abort_wait_state", 16'(bus.state_o), 16'd0);
    check_output("abort_wait_busy", 16'(bus.busy_o), 16'd0);
`else
    $display("[TB] direct start build");

    // Three captures, 10-cycle gaps, done 20 cycles into each capture
    bus.csr_num_caps_i = 8'd3;
    bus.csr_holdoff_i  = 16'd10;
    apply_stimulus(1'b1, 1'b0);
    bus.csr_num_caps_i = 8'd1;
    bus.csr_holdoff_i  = 16'd50;
    check_output("seq_first_state", 16'(bus.state_o), 16'd2);
    check_output("seq_first_busy", 16'(bus.busy_o), 16'd1);
    for (int i = 0; i < 3; i++) begin
      step(20);
      check_output("seq_start_high", 16'(bus.cap_start_o), 16'd1);
      bus.cap_done_i = 1'b1;
      step(1);
      bus.cap_done_i = 1'b0;
      check_output("seq_start_low", 16'(bus.cap_start_o), 16'd0);
      check_output("seq_count", 16'(bus.cap_count_o), 16'(i + 1));
      check_output("seq_irq", 16'(bus.irq_o), (i == 2) ? 16'd1 : 16'd0);
      check_output("seq_state", 16'(bus.state_o), (i == 2) ? 16'd0 : 16'd3);
      if (i < 2) begin
        measure_gap(gap);
        check_output("seq_gap", 16'(gap), 16'd10);
      end
    end
    step(1);
    check_output("seq_irq_pulse", 16'(bus.irq_o), 16'd0);
    check_output("seq_busy_after", 16'(bus.busy_o), 16'd0);
    check_output("seq_count_after", 16'(bus.cap_count_o), 16'd3);

    // Stale done held high at arm must be masked for two cycles
    bus.csr_num_caps_i = 8'd1;
    bus.csr_holdoff_i  = 16'd10;
    bus.cap_done_i     = 1'b1;
    apply_stimulus(1'b1, 1'b0);
    check_output("stale_start0", 16'(bus.cap_start_o), 16'd1);
    step(1);
    check_output("stale_start1", 16'(bus.cap_start_o), 16'd1);
    step(1);
    check_output("stale_start2", 16'(bus.cap_start_o), 16'd1);
    bus.cap_done_i = 1'b0;
    step(5);
    check_output("stale_still_cap", 16'(bus.cap_start_o), 16'd1);
    check_output("stale_count0", 16'(bus.cap_count_o), 16'd0);
    bus.cap_done_i = 1'b1;
    step(1);
    bus.cap_done_i = 1'b0;
    check_output("stale_done_start", 16'(bus.cap_start_o), 16'd0);
    check_output("stale_done_count", 16'(bus.cap_count_o), 16'd1);
    check_output("stale_done_irq", 16'(bus.irq_o), 16'd1);

    // Continuous mode with minimum gap, ignored re-arm, then abort
    step(1);
    bus.csr_num_caps_i = 8'd0;
    bus.csr_holdoff_i  = 16'd0;
    apply_stimulus(1'b1, 1'b0);
    check_output("cont_count_clear", 16'(bus.cap_count_o), 16'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        apply_stimulus(1'b1, 1'b0);
        check_output("cont_arm_ignored", 16'(bus.cap_count_o), 16'd1);
      end else begin
        step(1);
      end
      step(1);
      bus.cap_done_i = 1'b1;
      step(1);
      bus.cap_done_i = 1'b0;
      check_output("cont_start_low", 16'(bus.cap_start_o), 16'd0);
      check_output("cont_state", 16'(bus.state_o), 16'd3);
      check_output("cont_count", 16'(bus.cap_count_o), 16'(i + 1));
      check_output("cont_irq", 16'(bus.irq_o), 16'd0);
      measure_gap(gap);
      check_output("cont_gap", 16'(gap), 16'd2);
    end
    step(1);
    apply_stimulus(1'b0, 1'b1);
    check_output("abort_state", 16'(bus.state_o), 16'd0);
    check_output("abort_start", 16'(bus.cap_start_o), 16'd0);
    check_output("abort_busy", 16'(bus.busy_o), 16'd0);
    check_output("abort_irq", 16'(bus.irq_o), 16'd0);
    check_output("abort_count", 16'(bus.cap_count_o), 16'd3);

    // Watchdog: done never arrives
    bus.csr_num_caps_i = 8'd1;
    apply_stimulus(1'b1, 1'b0);
    step(8191);
    check_output("wd_last_cycle", 16'(bus.cap_start_o), 16'd1);
    check_output("wd_not_yet", 16'(bus.timeout_o), 16'd0);
    step(1);
    check_output("wd_start", 16'(bus.cap_start_o), 16'd0);
    check_output("wd_timeout", 16'(bus.timeout_o), 16'd1);
    check_output("wd_irq", 16'(bus.irq_o), 16'd0);
    check_output("wd_state", 16'(bus.state_o), 16'd0);
    check_output("wd_count", 16'(bus.cap_count_o), 16'd0);
    step(1);
    check_output("wd_sticky", 16'(bus.timeout_o), 16'd1);
    check_output("wd_irq_later", 16'(bus.irq_o), 16'd0);

    // Arm and abort together: abort wins, nothing cleared
    apply_stimulus(1'b1, 1'b1);
    check_output("armabort_state", 16'(bus.state_o), 16'd0);
    check_output("armabort_busy", 16'(bus.busy_o), 16'd0);
    check_output("armabort_tmo", 16'(bus.timeout_o), 16'd1);

    // Reset asserted mid-HOLDOFF clears everything without a clock edge
    bus.csr_num_caps_i = 8'd2;
    bus.csr_holdoff_i  = 16'd10;
    apply_stimulus(1'b1, 1'b0);
    check_output("arm_clears_tmo", 16'(bus.timeout_o), 16'd0);
    step(2);
    bus.cap_done_i = 1'b1;
    step(1);
    bus.cap_done_i = 1'b0;
    check_output("hold_state", 16'(bus.state_o), 16'd3);
    check_output("hold_count", 16'(bus.cap_count_o), 16'd1);
    step(1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("rst_hold");
    step(1);
    sys_rst_n = 1'b1;
    step(1);

    // Reset asserted mid-capture drops the start level immediately
    apply_stimulus(1'b1, 1'b0);
    check_output("rst_cap_before", 16'(bus.cap_start_o), 16'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_output("rst_cap_start", 16'(bus.cap_start_o), 16'd0);
    check_output("rst_cap_state", 16'(bus.state_o), 16'd0);
    step(1);
    sys_rst_n = 1'b1;
    step(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
